// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word through a
// 2-stage valid/ready pipeline and tags each word with an imem byte address.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 base_load,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [6:0]  OpLw   = 7'b0000011;
   localparam logic [6:0]  OpAddi = 7'b0010011;
   localparam logic [6:0]  OpSw   = 7'b0100011;
   localparam logic [6:0]  OpBeq  = 7'b1100011;
   localparam logic [6:0]  OpR    = 7'b0110011;
   localparam logic [31:0] Nop    = 32'h0000_0013;

   logic        s1_v_q, s1_err_q;
   logic [6:0]  s1_op_q, s1_f7_q;
   logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
   logic [2:0]  s1_f3_q;
   logic [31:0] s1_imm_q;

   logic                 s2_v_q, s2_err_q;
   logic [31:0]          s2_instr_q;
   logic [ADDR_W-1:0]    s2_addr_q;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   logic        s2_adv, out_fire, in_err, imm12_ok, imm13_ok;
   logic [31:0] word;

   assign out_fire = s2_v_q && out_ready;
   assign s2_adv   = !s2_v_q || out_ready;
   assign in_ready = !s1_v_q || s2_adv;

   // Range checks: upper bits must all be copies of the sign bit.
   assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign imm13_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];

   always_comb begin
      in_err = 1'b0;
      case (in_opcode)
         OpLw, OpAddi, OpSw: in_err = !imm12_ok;
         OpBeq:              in_err = !imm13_ok;
         OpR:                in_err = 1'b0;
         default:            in_err = 1'b1;
      endcase
   end

   always_comb begin
      word = Nop;
      if (!s1_err_q) begin
         case (s1_op_q)
            OpLw, OpAddi: word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            OpSw:         word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                  s1_imm_q[4:0], s1_op_q};
            OpBeq:        word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                  s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            OpR:          word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            default:      word = Nop;
         endcase
      end
   end

   // addr_d is also the tag for a word entering S2 this cycle, so a word that
   // replaces a departing one already sees that departure's increment.
   always_comb begin
      addr_d = addr_q;
      if (base_load)     addr_d = base_addr & ~ADDR_W'(3);
      else if (out_fire) addr_d = addr_q + ADDR_W'(4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q   <= 1'b0;
         s1_err_q <= 1'b0;
         s1_op_q  <= '0;
         s1_f7_q  <= '0;
         s1_rd_q  <= '0;
         s1_rs1_q <= '0;
         s1_rs2_q <= '0;
         s1_f3_q  <= '0;
         s1_imm_q <= '0;
      end else if (in_ready) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_err_q <= in_err;
            s1_op_q  <= in_opcode;
            s1_f7_q  <= in_funct7;
            s1_rd_q  <= in_rd;
            s1_rs1_q <= in_rs1;
            s1_rs2_q <= in_rs2;
            s1_f3_q  <= in_funct3;
            s1_imm_q <= in_imm;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q     <= 1'b0;
         s2_err_q   <= 1'b0;
         s2_instr_q <= '0;
         s2_addr_q  <= '0;
      end else if (s2_adv) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_err_q   <= s1_err_q;
            s2_instr_q <= word;
            s2_addr_q  <= addr_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         addr_q <= addr_d;
         if (out_fire && s2_err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign out_valid = s2_v_q;
   assign out_instr = s2_instr_q;
   assign out_addr  = s2_addr_q;
   assign out_err   = s2_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table through a queue-fed driver, scoreboard
// monitor with address/error-count model, plus reset, stall and base_load sequences.
module tb_instr_encoder;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        base_load = 1'b0;
   logic [11:0] base_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [11:0] out_addr;
   logic        out_err;
   logic [7:0]  err_cnt;

   logic        in_ready4, out_valid4, out_err4;
   logic [31:0] out_instr4;
   logic [3:0]  out_addr4;
   logic [7:0]  err_cnt4;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;

   vec_t        stim[$];
   vec_t        sb[$];
   vec_t        vecs[$];
   logic [11:0] exp_next = '0;
   logic [7:0]  exp_cnt = '0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_instr;
   logic [11:0] prev_addr;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(12), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
   );

   // Narrow-address twin, driven identically, to observe 4-bit wrap.
   instr_encoder #(.ADDR_W(4), .ERR_CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr[3:0]),
      .in_valid(in_valid), .in_ready(in_ready4), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .out_valid(out_valid4), .out_ready(out_ready),
      .out_instr(out_instr4), .out_addr(out_addr4), .out_err(out_err4), .err_cnt(err_cnt4)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] ei, input logic ee);
      vec_t v;
      v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.exp_instr = ei; v.exp_err = ee;
      return v;
   endfunction

   // Driver: presents the head of stim; an accepted item moves to the scoreboard.
   initial begin
      logic acc;
      forever begin
         @(negedge clk);
         acc = rst_n && in_valid && in_ready;
         @(posedge clk);
         if (acc && stim.size() > 0) begin
            sb.push_back(stim.pop_front());
            n_acc++;
         end
         #1;
         if (stim.size() > 0) begin
            in_valid  = 1'b1;
            in_opcode = stim[0].op;  in_rd  = stim[0].rd;  in_rs1 = stim[0].rs1;
            in_rs2    = stim[0].rs2; in_funct3 = stim[0].f3; in_funct7 = stim[0].f7;
            in_imm    = stim[0].imm;
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   // Monitor: compares each output handshake against the scoreboard and models.
   always @(negedge clk) begin
      vec_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
         if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, prev_instr);
            chk("stall_addr", 32'(out_addr), 32'(prev_addr));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", out_instr, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("instr", out_instr, e.exp_instr);
               chk("err", 32'(out_err), 32'(e.exp_err));
               chk("addr", 32'(out_addr), 32'(exp_next));
               chk("addr4", 32'(out_addr4), 32'(exp_next[3:0]));
               exp_next = exp_next + 12'd4;
               if (out_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_addr  = out_addr;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      stim.delete(); sb.delete();
      exp_next = '0; exp_cnt = '0; base_load = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      logic done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (stim.size() == 0) && (sb.size() == 0) && !out_valid && !in_valid;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic set_base(input logic [11:0] b);
      @(posedge clk); #1;
      base_load = 1'b1; base_addr = b; exp_next = b & ~12'd3;
      @(posedge clk); #1;
      base_load = 1'b0;
   endtask

   initial begin
      logic ok;
      int   acc0;

      vecs.push_back(mk(7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0));
      vecs.push_back(mk(7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8, 32'h0080_A103, 1'b0));
      vecs.push_back(mk(7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 32'h0020_A623, 1'b0));
      vecs.push_back(mk(7'h63, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE20_8EE3, 1'b0));
      vecs.push_back(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0));
      vecs.push_back(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h8000_0093, 1'b0));
      vecs.push_back(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1));
      vecs.push_back(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1));
      vecs.push_back(mk(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1));
      vecs.push_back(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0));
      vecs.push_back(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0013, 1'b1));

      do_reset();

      // Latency: accept edge, then S1, then out_valid.
      stim.push_back(vecs[0]);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_valid && in_ready;
      end
      chk("lat_accept", 32'(ok), 32'd1);
      @(negedge clk); chk("lat_cycle1", 32'(out_valid), 32'd0);
      @(negedge clk); chk("lat_cycle2", 32'(out_valid), 32'd1);

      for (int i = 1; i < vecs.size(); i++) stim.push_back(vecs[i]);
      wait_drain("table_drain");
      chk("table_err_cnt", 32'(err_cnt), 32'd4);

      // Reset with words in flight: all dropped.
      for (int i = 0; i < 3; i++) stim.push_back(vecs[i]);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      chk("midrst_inflight", 32'(ok), 32'd1);
      do_reset();
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_ghost", 32'(out_valid), 32'd0);
      end

      // Five back-to-back words against a stalled sink.
      @(posedge clk); #1;
      out_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 5; i++)
         stim.push_back(mk(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'(i + 1),
                           {12'(i + 1), 5'd4, 3'd0, 5'd4, 7'h13}, 1'b0));
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("stall_accepted", 32'(n_acc - acc0), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain("stall_drain");
      chk("stall_total", 32'(n_acc - acc0), 32'd5);

      // base_load with empty pipeline, low bits cleared.
      set_base(12'h101);
      stim.push_back(vecs[1]);
      wait_drain("base_drain");
      chk("base_next", 32'(exp_next), 32'h104);

      // Wrap: 12-bit 0xFFC->0x000, 4-bit 0xC->0x0.
      set_base(12'hFFC);
      stim.push_back(vecs[2]);
      stim.push_back(vecs[3]);
      wait_drain("wrap_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
